// File: rtl/irda_fir_4ppm_encoder_pkg.sv
// Shared constants, types and the 4PPM symbol map for the FIR (4 Mb/s) modulator.
// Provides: flag/preamble chip words, segment end indices, FSM state type,
// holding-register payload type, and the dibit/byte to 4PPM chip mapping.
package irda_fir_4ppm_encoder_pkg;

    localparam int unsigned CHIP_IDX_W = 5;
    localparam int unsigned REP_W      = 5;
    localparam int unsigned SHREG_W    = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BYTE_CHIPS = 16;

    // Chip words, leftmost chip transmitted first.
    localparam logic [15:0] PREAMBLE_WORD = 16'b1000_0000_1010_1000;
    localparam logic [31:0] START_WORD    = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
    localparam logic [31:0] STOP_WORD     = 32'b0000_1100_0000_1100_0000_0110_0000_0110;

    // Index of the final chip in 16- and 32-chip segments.
    localparam logic [CHIP_IDX_W-1:0] SEG16_END = CHIP_IDX_W'(15);
    localparam logic [CHIP_IDX_W-1:0] SEG32_END = CHIP_IDX_W'(31);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // Byte held between framer handshake and shift-register load.
    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } tx_byte_t;

    // One dibit to one 4-chip symbol; the pulse position encodes the value.
    function automatic logic [3:0] ppm_symbol(input logic [1:0] dibit);
        logic [3:0] sym;
        case (dibit)
            2'b00:   sym = 4'b1000;
            2'b01:   sym = 4'b0100;
            2'b10:   sym = 4'b0010;
            default: sym = 4'b0001;
        endcase
        return sym;
    endfunction

    // Whole byte to 16 chips, least significant dibit transmitted first.
    function automatic logic [BYTE_CHIPS-1:0] ppm_byte(input logic [BYTE_W-1:0] b);
        return {ppm_symbol(b[1:0]), ppm_symbol(b[3:2]), ppm_symbol(b[5:4]), ppm_symbol(b[7:6])};
    endfunction

endpackage

// File: rtl/irda_fir_4ppm_encoder.sv
// FIR 4PPM modulator: preamble, start flag, 4PPM data bytes, stop flag, one chip per strobe.
// Ports:
//   clk, wb_rst_n_i       clock, asynchronous active-low reset
//   enable_i              FIR mode selected; low returns to idle on the next clock
//   chip_en_i             one-clock strobe per chip period
//   frame_start_i         start a frame (only taken in idle)
//   byte_i/_valid_i/_last_i, byte_ready_o   framer byte handshake (accept on valid & ready)
//   chip_o                registered chip to the pad mux (1 = LED on)
//   busy_o                frame in progress
//   underrun_o            one-clock pulse when data starves mid-frame
module irda_fir_4ppm_encoder
    import irda_fir_4ppm_encoder_pkg::*;
#(
    parameter int unsigned PREAMBLE_REPS = 16
) (
    input  logic              clk,
    input  logic              wb_rst_n_i,
    input  logic              enable_i,
    input  logic              chip_en_i,
    input  logic              frame_start_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              byte_valid_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic              chip_o,
    output logic              busy_o,
    output logic              underrun_o
);

    localparam logic [REP_W-1:0] REP_LAST = REP_W'(PREAMBLE_REPS - 1);

    state_t                 state_q, state_d;
    logic [SHREG_W-1:0]     shreg_q, shreg_d;
    logic [CHIP_IDX_W-1:0]  idx_q, idx_d;
    logic [REP_W-1:0]       rep_q, rep_d;
    tx_byte_t               hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   cur_last_q, cur_last_d;
    logic                   last_seen_q, last_seen_d;
    logic                   chip_q, chip_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;
    logic                   underrun_q, underrun_d;
    logic [CHIP_IDX_W-1:0]  seg_end;
    logic                   accept;

    assign accept  = byte_valid_i & ready_q;
    assign seg_end = (state_q == ST_PREAMBLE || state_q == ST_DATA) ? SEG16_END : SEG32_END;

    // State and output registers.
    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            rep_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cur_last_q  <= 1'b0;
            last_seen_q <= 1'b0;
            chip_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            rep_q       <= rep_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cur_last_q  <= cur_last_d;
            last_seen_q <= last_seen_d;
            chip_q      <= chip_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            underrun_q  <= underrun_d;
        end
    end

    // Next-state, shift register, holding register and next-output logic.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        rep_d       = rep_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cur_last_d  = cur_last_q;
        last_seen_d = last_seen_q;
        chip_d      = chip_q;
        underrun_d  = 1'b0;

        // Ready implies the holding register is empty, so this never collides with a load.
        if (accept) begin
            hold_d      = '{last: byte_last_i, data: byte_i};
            hold_full_d = 1'b1;
            last_seen_d = last_seen_q | byte_last_i;
        end

        if (state_q == ST_IDLE) begin
            chip_d = 1'b0;
            if (frame_start_i) begin
                state_d     = ST_PREAMBLE;
                shreg_d     = {PREAMBLE_WORD, 16'h0000};
                idx_d       = '0;
                rep_d       = '0;
                hold_full_d = 1'b0;
                cur_last_d  = 1'b0;
                last_seen_d = 1'b0;
            end
        end else if (chip_en_i) begin
            chip_d  = shreg_q[SHREG_W-1];
            shreg_d = {shreg_q[SHREG_W-2:0], 1'b0};
            idx_d   = idx_q + CHIP_IDX_W'(1);
            if (idx_q == seg_end) begin
                idx_d = '0;
                unique case (state_q)
                    ST_PREAMBLE: begin
                        if (rep_q == REP_LAST) begin
                            state_d = ST_START;
                            shreg_d = START_WORD;
                            rep_d   = '0;
                        end else begin
                            shreg_d = {PREAMBLE_WORD, 16'h0000};
                            rep_d   = rep_q + REP_W'(1);
                        end
                    end
                    ST_START, ST_DATA: begin
                        // A byte marked last ends the data; otherwise the next byte must be waiting.
                        if (state_q == ST_DATA && cur_last_q) begin
                            state_d = ST_STOP;
                            shreg_d = STOP_WORD;
                        end else if (hold_full_q) begin
                            state_d     = ST_DATA;
                            shreg_d     = {ppm_byte(hold_q.data), 16'h0000};
                            cur_last_d  = hold_q.last;
                            hold_full_d = 1'b0;
                        end else begin
                            state_d    = ST_STOP;
                            shreg_d    = STOP_WORD;
                            underrun_d = 1'b1;
                        end
                    end
                    ST_STOP: begin
                        state_d     = ST_IDLE;
                        hold_full_d = 1'b0;
                        last_seen_d = 1'b0;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // Mode deselect aborts everything silently.
        if (!enable_i) begin
            state_d     = ST_IDLE;
            chip_d      = 1'b0;
            idx_d       = '0;
            rep_d       = '0;
            hold_full_d = 1'b0;
            cur_last_d  = 1'b0;
            last_seen_d = 1'b0;
            underrun_d  = 1'b0;
        end

        busy_d  = (state_d != ST_IDLE);
        ready_d = !hold_full_d && !last_seen_d && (state_d == ST_START || state_d == ST_DATA);
    end

    assign chip_o       = chip_q;
    assign busy_o       = busy_q;
    assign byte_ready_o = ready_q;
    assign underrun_o   = underrun_q;

endmodule
